oai21_pipe_array: RTL and testbench
===================================

Name: oai21_pipe_array

Overview:
- Parametrised, registered successor to the single-bit OAI21 cell.
- Evaluates WIDTH independent lanes of a selectable 2-level and-or/or-and function.
- Carries each result through a DEPTH-stage valid/ready pipeline that collapses bubbles.
- Used as a library-level macro wherever wide complex-gate logic must be retimed and flow-controlled. A saturating counter reports how many results have been delivered.

Parameters:
- WIDTH, 8: number of lanes; bit i of every data bus is lane i.
- DEPTH, 2: pipeline stages, 1 or greater; this is the latency in cycles with no stall.
- CNT_W, 8: width of the delivered-result counter.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  upstream presents an operand set.
- IN_READY  output  1  block can accept an operand set this cycle.
- MODE  input  2  function select, captured with the operands.
- A  input  WIDTH  per-lane A operand.
- B1  input  WIDTH  per-lane B1 operand.
- B2  input  WIDTH  per-lane B2 operand.
- OUT_VALID  output  1  ZN holds a valid result.
- OUT_READY  input  1  downstream accepts the result.
- ZN  output  WIDTH  per-lane result from the last stage.
- CNT  output  CNT_W  number of results delivered, saturating.
- CNT_CLR  input  1  synchronous clear of CNT.

Behaviour:
- Function is computed combinationally at the input; only the result enters stage 0. Per lane i:
  - MODE=00 (OAI21): ZN = ~(A & (B1 | B2)).
  - MODE=01 (AOI21): ZN = ~(A | (B1 & B2)).
  - MODE=10 (OA21): ZN = A & (B1 | B2).
  - MODE=11 (AO21): ZN = A | (B1 & B2).
- Per-stage state: a valid bit v[k] and a WIDTH-bit data register d[k], for k = 0..DEPTH-1. Stage DEPTH-1 drives ZN and OUT_VALID.
- Stage advance rules:
  - Stage k advances when adv[k] = ~v[k] | adv[k+1].
  - adv[DEPTH] = OUT_READY.
  - IN_READY = adv[0]. It is purely combinational from state and OUT_READY; no input-to-ready path exists.
- Transfers:
  - Input transfer occurs when IN_VALID & IN_READY.
  - Output transfer occurs when OUT_VALID & OUT_READY.
- On adv[k]:
  - v[k] takes v[k-1] (or IN_VALID for k=0).
  - d[k] takes d[k-1] (or the computed function for k=0).
  - Data registers load only when the incoming valid is 1; otherwise d[k] holds.
- Latency and throughput:
  - An input accepted at edge n appears on ZN with OUT_VALID=1 after edge n+DEPTH-1. It is visible in the cycle following that edge, i.e. DEPTH edges after it is presented.
  - Full throughput is one transfer per cycle while OUT_READY=1.
- Stall:
  - While OUT_READY=0, ZN and OUT_VALID hold stable.
  - Upstream bubbles collapse; IN_READY stays 1 until every stage is valid.
  - With all DEPTH stages full and OUT_READY=0, IN_READY=0.
  - Full and OUT_READY=1 gives simultaneous in and out transfers; occupancy is unchanged.
- No data is dropped or duplicated. Results leave in acceptance order.
- CNT:
  - Increments by 1 on each output transfer.
  - Saturates at 2^CNT_W-1 and never wraps.
  - CNT_CLR=1 sets CNT to 0 at the edge; this takes priority over a same-cycle increment.
- Reset:
  - RST=1 immediately forces all v[k]=0, all d[k]=0 and CNT=0.
  - Therefore OUT_VALID=0, ZN=0 and IN_READY=1 while in reset.
  - Reset mid-stream discards in-flight results; they are not counted.
  - Deassertion is used synchronised externally; there is no first-cycle special case.
- MODE is sampled per transfer. Changing MODE between transfers affects only subsequent operand sets.
- X on inputs while IN_VALID=0 must not propagate into v[] or CNT.

Test Plan:
- Reset: assert RST mid-cycle with 2 results in flight. Required: OUT_VALID=0, ZN=0, CNT=0 and IN_READY=1 asynchronously; after release, no stale result emerges.
- Truth table (WIDTH=8, DEPTH=2, OUT_READY=1): send A=8'hF0, B1=8'hCC, B2=8'hAA once in each of MODE 00/01/10/11. Required ZN, in order: 8'h1F, 8'h07, 8'hE0, 8'hF8. Each appears 2 cycles after its transfer; CNT=4.
- Stall: OUT_READY=0 and 3 inputs offered back-to-back. Required: 2 accepted, then IN_READY=0 and ZN held stable. Release OUT_READY: results delivered in order, IN_READY=1 in the same cycle.
- Bubble collapse: one input, 1 idle cycle, one input, with OUT_READY=0. Required: both stages fill and IN_READY falls only after the second acceptance.
- Counter: CNT_W=2; deliver 5 results. Required: CNT reads 1, 2, 3, 3, 3. CNT_CLR coincident with a transfer gives CNT=0.
- Throughput: 16 consecutive inputs with OUT_READY=1. Required: 16 consecutive output cycles, no gaps, IN_READY constantly 1.

Source files
------------

// File: rtl/oai21_pipe_array.sv
// WIDTH-lane selectable and-or/or-and gate array feeding a DEPTH-stage
// bubble-collapsing valid/ready pipeline with a saturating delivery counter.
module oai21_pipe_array #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B1,
    input  logic [WIDTH-1:0] B2,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] ZN,
    output logic [CNT_W-1:0] CNT,
    input  logic             CNT_CLR
);

    localparam logic [1:0]       MODE_OAI21 = 2'b00;
    localparam logic [1:0]       MODE_AOI21 = 2'b01;
    localparam logic [1:0]       MODE_OA21  = 2'b10;
    localparam logic [1:0]       MODE_AO21  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [WIDTH-1:0] w_func;
    logic [DEPTH:0]   w_adv;
    logic [DEPTH-1:0] w_vin;
    logic [WIDTH-1:0] w_din [DEPTH];
    logic             w_out_xfer;

    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [CNT_W-1:0] r_cnt;

    // Per-lane gate function evaluated ahead of stage 0.
    always_comb begin
        w_func = '0;
        case (MODE)
            MODE_OAI21: w_func = ~(A & (B1 | B2));
            MODE_AOI21: w_func = ~(A | (B1 & B2));
            MODE_OA21:  w_func = A & (B1 | B2);
            MODE_AO21:  w_func = A | (B1 & B2);
            default:    w_func = '0;
        endcase
    end

    // A stage may advance if it is empty or everything downstream can move.
    always_comb begin
        w_adv        = '0;
        w_adv[DEPTH] = OUT_READY;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            w_adv[k] = ~r_v[k] | w_adv[k+1];
        end
    end

    always_comb begin
        w_vin    = '0;
        w_vin[0] = IN_VALID;
        w_din[0] = w_func;
        for (int k = 1; k < int'(DEPTH); k++) begin
            w_vin[k] = r_v[k-1];
            w_din[k] = r_d[k-1];
        end
    end

    // Data registers only load behind a valid bit so idle inputs never leak in.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_v <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                r_d[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (w_adv[k]) begin
                    r_v[k] <= w_vin[k];
                    if (w_vin[k]) begin
                        r_d[k] <= w_din[k];
                    end
                end
            end
        end
    end

    assign w_out_xfer = r_v[DEPTH-1] & OUT_READY;

    // Delivered-result counter; clear wins over a same-cycle increment.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (CNT_CLR) begin
            r_cnt <= '0;
        end else if (w_out_xfer && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign IN_READY  = w_adv[0];
    assign OUT_VALID = r_v[DEPTH-1];
    assign ZN        = r_d[DEPTH-1];
    assign CNT       = r_cnt;

endmodule

// File: tb/tb_oai21_pipe_array.sv
// Directed bench for oai21_pipe_array: a queue-based occupancy model is
// compared every cycle, and literal expectations pin the model itself.
module tb_oai21_pipe_array;

    localparam int unsigned W = 8;
    localparam int unsigned D = 2;

    logic         CK = 1'b0;
    logic         RST;
    logic         IN_VALID;
    logic [1:0]   MODE;
    logic [W-1:0] A, B1, B2;
    logic         OUT_READY;
    logic         CNT_CLR;
    logic         in_ready, out_valid, in_ready2, out_valid2;
    logic [W-1:0] zn, zn2;
    logic [7:0]   cnt;
    logic [1:0]   cnt2;

    int checks = 0;
    int errors = 0;

    always #5 CK = ~CK;

    oai21_pipe_array #(.WIDTH(W), .DEPTH(D), .CNT_W(8)) u_dut (
        .CK(CK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(in_ready),
        .MODE(MODE), .A(A), .B1(B1), .B2(B2), .OUT_VALID(out_valid),
        .OUT_READY(OUT_READY), .ZN(zn), .CNT(cnt), .CNT_CLR(CNT_CLR)
    );

    oai21_pipe_array #(.WIDTH(W), .DEPTH(D), .CNT_W(2)) u_dut2 (
        .CK(CK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(in_ready2),
        .MODE(MODE), .A(A), .B1(B1), .B2(B2), .OUT_VALID(out_valid2),
        .OUT_READY(OUT_READY), .ZN(zn2), .CNT(cnt2), .CNT_CLR(CNT_CLR)
    );

    // Model: FIFO of results, each with the pipeline position it has reached.
    typedef struct {
        logic [W-1:0] d;
        int           pos;
    } item_t;

    item_t        mq[$];
    int           m_cnt  = 0;
    int           m_cnt2 = 0;
    int           edge_n = 0;
    logic [W-1:0] log_d[$];
    int           log_e[$];
    int           acc_e[$];

    function automatic logic [W-1:0] ref_fn(input logic [1:0] m, input logic [W-1:0] a, b1, b2);
        case (m)
            2'b00:   return ~(a & (b1 | b2));
            2'b01:   return ~(a | (b1 & b2));
            2'b10:   return a & (b1 | b2);
            default: return a | (b1 & b2);
        endcase
    endfunction

    function automatic bit m_ov();
        return (mq.size() > 0) && (mq[0].pos == int'(D) - 1);
    endfunction

    function automatic bit m_ir();
        return (mq.size() < int'(D)) || (m_ov() && (OUT_READY === 1'b1));
    endfunction

    always @(posedge CK or posedge RST) begin : p_model
        bit    ox;
        bit    ix;
        int    cap;
        int    np;
        item_t it;
        if (RST) begin
            mq.delete();
            m_cnt  = 0;
            m_cnt2 = 0;
        end else begin
            ox = m_ov() && (OUT_READY === 1'b1);
            ix = (IN_VALID === 1'b1) && m_ir();
            edge_n++;
            if (ox) begin
                log_d.push_back(mq[0].d);
                log_e.push_back(edge_n);
                void'(mq.pop_front());
            end
            if (CNT_CLR === 1'b1) begin
                m_cnt  = 0;
                m_cnt2 = 0;
            end else if (ox) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            // Each result moves forward unless the one ahead blocks it.
            cap = int'(D) - 1;
            foreach (mq[i]) begin
                np = (mq[i].pos + 1 < cap) ? mq[i].pos + 1 : cap;
                mq[i].pos = np;
                cap = np - 1;
            end
            if (ix) begin
                it.d   = ref_fn(MODE, A, B1, B2);
                it.pos = 0;
                mq.push_back(it);
                acc_e.push_back(edge_n);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CK) begin
        chk("in_ready", 32'(in_ready), 32'(m_ir()));
        chk("out_valid", 32'(out_valid), 32'(m_ov()));
        chk("out_valid2", 32'(out_valid2), 32'(m_ov()));
        if (m_ov()) begin
            chk("zn", 32'(zn), 32'(mq[0].d));
            chk("zn2", 32'(zn2), 32'(mq[0].d));
        end
        chk("cnt", 32'(cnt), 32'(m_cnt));
        chk("cnt2", 32'(cnt2), 32'(m_cnt2));
    end

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic idle();
        IN_VALID = 1'b0;
        MODE     = 'x;
        A        = 'x;
        B1       = 'x;
        B2       = 'x;
    endtask

    task automatic setin(input logic [1:0] m, input logic [W-1:0] a, b1, b2);
        IN_VALID = 1'b1;
        MODE     = m;
        A        = a;
        B1       = b1;
        B2       = b2;
    endtask

    task automatic offer(input logic [1:0] m, input logic [W-1:0] a, b1, b2);
        logic acc;
        acc = 1'b0;
        setin(m, a, b1, b2);
        for (int n = 0; n < 50; n++) begin
            acc = in_ready;
            step();
            if (acc) break;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL offer_timeout actual=%0h required=1", acc);
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : p_stim
        logic [W-1:0] tt_exp [4];
        logic         rdy [4];
        logic [W-1:0] zh;
        logic [1:0]   c2_exp [5];
        int           base;
        int           abase;
        int           nlow;

        RST       = 1'b1;
        CNT_CLR   = 1'b0;
        OUT_READY = 1'b1;
        idle();
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_zn", 32'(zn), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        RST = 1'b0;
        step();

        // Truth table, one operand set per mode.
        tt_exp = '{8'h1F, 8'h07, 8'hE0, 8'hF8};
        base  = log_d.size();
        abase = acc_e.size();
        for (int m = 0; m < 4; m++) offer(2'(m), 8'hF0, 8'hCC, 8'hAA);
        repeat (4) step();
        chk("tt_count", 32'(log_d.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (log_d.size() > base + i) begin
                chk("tt_zn", 32'(log_d[base+i]), 32'(tt_exp[i]));
                chk("tt_latency", 32'(log_e[base+i] - acc_e[abase+i]), 32'(D));
            end
        end
        chk("tt_cnt", 32'(cnt), 32'd4);

        // Async reset with two results in flight.
        OUT_READY = 1'b0;
        offer(2'b11, 8'h01, 8'h00, 8'h00);
        offer(2'b11, 8'h02, 8'h00, 8'h00);
        #3;
        RST = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_zn", 32'(zn), 32'd0);
        chk("mid_rst_cnt", 32'(cnt), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        step();
        step();
        RST       = 1'b0;
        OUT_READY = 1'b1;
        base = log_d.size();
        repeat (4) step();
        chk("no_stale_result", 32'(log_d.size() - base), 32'd0);

        // Stall: three back-to-back offers into a blocked pipeline.
        OUT_READY = 1'b0;
        setin(2'b11, 8'hFF, 8'h00, 8'h00); rdy[0] = in_ready; step();
        setin(2'b10, 8'h0F, 8'hFF, 8'h00); rdy[1] = in_ready; step();
        setin(2'b00, 8'hFF, 8'hFF, 8'hFF); rdy[2] = in_ready; step();
        idle();
        chk("stall_rdy0", 32'(rdy[0]), 32'd1);
        chk("stall_rdy1", 32'(rdy[1]), 32'd1);
        chk("stall_rdy2", 32'(rdy[2]), 32'd0);
        zh = zn;
        chk("stall_zn_first", 32'(zh), 32'hFF);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_zn_hold", 32'(zn), 32'(zh));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        OUT_READY = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        base = log_d.size();
        repeat (4) step();
        chk("stall_count", 32'(log_d.size() - base), 32'd2);
        if (log_d.size() >= base + 2) begin
            chk("stall_order0", 32'(log_d[base]), 32'hFF);
            chk("stall_order1", 32'(log_d[base+1]), 32'h0F);
        end

        // Bubble collapse.
        OUT_READY = 1'b0;
        setin(2'b11, 8'hA5, 8'h00, 8'h00); rdy[0] = in_ready; step();
        idle();                            rdy[1] = in_ready; step();
        setin(2'b10, 8'h3C, 8'hFF, 8'h00); rdy[2] = in_ready; step();
        idle();                            rdy[3] = in_ready;
        chk("bub_rdy0", 32'(rdy[0]), 32'd1);
        chk("bub_rdy1", 32'(rdy[1]), 32'd1);
        chk("bub_rdy2", 32'(rdy[2]), 32'd1);
        chk("bub_rdy3", 32'(rdy[3]), 32'd0);
        OUT_READY = 1'b1;
        base = log_d.size();
        repeat (4) step();
        chk("bub_count", 32'(log_d.size() - base), 32'd2);
        if (log_d.size() >= base + 2) begin
            chk("bub_order0", 32'(log_d[base]), 32'hA5);
            chk("bub_order1", 32'(log_d[base+1]), 32'h3C);
        end

        // Counter saturation on the 2-bit instance, then clear vs increment.
        CNT_CLR = 1'b1;
        step();
        CNT_CLR = 1'b0;
        c2_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int k = 0; k < 5; k++) begin
            offer(2'b11, 8'(k), 8'h00, 8'h00);
            step();
            step();
            chk("cnt2_sat", 32'(cnt2), 32'(c2_exp[k]));
            chk("cnt8_inc", 32'(cnt), 32'(k + 1));
        end
        offer(2'b11, 8'h77, 8'h00, 8'h00);
        step();
        chk("clr_pre_valid", 32'(out_valid), 32'd1);
        CNT_CLR = 1'b1;
        step();
        CNT_CLR = 1'b0;
        chk("clr_cnt2", 32'(cnt2), 32'd0);
        chk("clr_cnt", 32'(cnt), 32'd0);

        // Throughput: sixteen consecutive inputs, free-flowing output.
        OUT_READY = 1'b1;
        base = log_d.size();
        nlow = 0;
        for (int i = 0; i < 16; i++) begin
            setin(2'(i), 8'(i * 17), ~8'(i), 8'(i));
            if (!in_ready) nlow++;
            step();
        end
        idle();
        repeat (4) step();
        chk("tp_ready_low", 32'(nlow), 32'd0);
        chk("tp_count", 32'(log_d.size() - base), 32'd16);
        if (log_d.size() >= base + 16) begin
            for (int i = 1; i < 16; i++) begin
                chk("tp_gap", 32'(log_e[base+i] - log_e[base+i-1]), 32'd1);
            end
            chk("tp_first", 32'(log_d[base]), 32'hFF);
            chk("tp_last", 32'(log_d[base+15]), 32'hFF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
